// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its address generator.
package lsu_pkg;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    READ,
    WRITE,
    RESP
  } lsu_state_t;
endpackage

// File: rtl/lsu_addr_gen.sv
// Effective-address generator: base plus sign-extended immediate, with word-alignment flag.
module lsu_addr_gen
  import lsu_pkg::*;
(
  input  logic [ADDR_W-1:0] base,
  input  logic [IMM_W-1:0]  offset,
  output logic [ADDR_W-1:0] ea,
  output logic              misaligned
);

  always_comb begin
    ea         = base + {{(ADDR_W-IMM_W){offset[IMM_W-1]}}, offset};
    misaligned = (ea[1:0] & ALIGN_MASK) != 2'b00;
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store initiator: one request at a time, drives the data-memory port,
// answers through a valid/ready response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] base,
  input  logic [IMM_W-1:0]  offset,
  input  logic [DATA_W-1:0] store_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_t        state, state_next;
  logic              wr_q;
  logic [ADDR_W-1:0] base_q;
  logic [IMM_W-1:0]  offset_q;
  logic [DATA_W-1:0] sdata_q;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] ea;
  logic              misaligned;

  lsu_addr_gen u_addr_gen (
    .base       (base_q),
    .offset     (offset_q),
    .ea         (ea),
    .misaligned (misaligned)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      base_q         <= '0;
      offset_q       <= '0;
      sdata_q        <= '0;
      cnt            <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_data      <= '0;
      resp_error     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q     <= req_write;
            base_q   <= base;
            offset_q <= offset;
            sdata_q  <= store_data;
          end
        end
        CALC: begin
          // Address is registered even when misaligned so it stays observable afterwards.
          mem_address <= ea;
          resp_data   <= '0;
          resp_error  <= misaligned;
          if (!misaligned && wr_q)  mem_write_data <= sdata_q;
          if (!misaligned && !wr_q) cnt            <= 4'(WAIT_CYCLES);
        end
        READ: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) resp_data <= mem_read_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = CALC;
      end
      CALC: begin
        if (misaligned)  state_next = RESP;
        else if (wr_q)   state_next = WRITE;
        else             state_next = READ;
      end
      READ: begin
        mem_read = 1'b1;
        if (cnt == 4'd1) state_next = RESP;
      end
      WRITE: begin
        mem_write  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
